clk_div_bank: RTL and testbench

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_bank.sv | 169 ++++++++++++++++
 tb/tb_clk_div_bank.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// PLL reset/lock sequencer feeding a bank of phase-aligned integer clock dividers.
// Dividers run only while the synchronised PLL lock has been stable long enough.
module clk_div_bank #(
  parameter int NUM_CH         = 3,
  parameter int CNT_W          = 8,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_STABLE    = 1024,
  parameter int RELOCK_TIMEOUT = 65536
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*CNT_W-1:0] div_ratio,
  input  logic [NUM_CH*CNT_W-1:0] phase_ofs,
  input  logic                    cfg_load,
  output logic                    pll_rst,
  output logic                    ready,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [7:0]              relock_count
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
  localparam int MAX_CYC = (MAX_A > RELOCK_TIMEOUT) ? MAX_A : RELOCK_TIMEOUT;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);
  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] STB_LAST = CYC_W'(LOCK_STABLE - 1);
  localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(RELOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;

  function automatic logic [CNT_W-1:0] eff_ratio(input logic [CNT_W-1:0] r);
    return (r == '0) ? CNT_W'(1) : r;
  endfunction

  function automatic logic [CNT_W-1:0] eff_ofs(input logic [CNT_W-1:0] o,
                                                input logic [CNT_W-1:0] reff);
    return (o > reff - CNT_W'(1)) ? reff - CNT_W'(1) : o;
  endfunction

  // ceil(reff/2) without widening: floor half plus the odd bit
  function automatic logic [CNT_W-1:0] half_len(input logic [CNT_W-1:0] reff);
    return (reff >> 1) + {{(CNT_W-1){1'b0}}, reff[0]};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                  state, state_nxt;
  logic [CYC_W-1:0]        cyc, cyc_nxt;
  logic                    sync_p0, lock_s;
  logic [NUM_CH*CNT_W-1:0] ratio_sh, ofs_sh;
  logic                    reload;
  logic [CNT_W-1:0]        cnt     [NUM_CH];
  logic [CNT_W-1:0]        cnt_nxt [NUM_CH];
  logic [CNT_W-1:0]        reff    [NUM_CH];
  logic [CNT_W-1:0]        oeff    [NUM_CH];
  logic [NUM_CH-1:0]       ce_nxt, clk_nxt;
  logic                    run_nxt, do_load, suppress;

  assign pll_rst = (state == RESET_PLL);
  assign ready   = (state == RUN);

  // A single cycle counter serves reset length, lock timeout and stability count.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    case (state)
      RESET_PLL: begin
        if (cyc == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc + CYC_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cyc_nxt   = '0;
        end else if (cyc == TMO_LAST) begin
          state_nxt = RESET_PLL;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc + CYC_W'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cyc_nxt   = '0;
        end else if (cyc == STB_LAST) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc + CYC_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = RESET_PLL;
          cyc_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RESET_PLL;
        cyc_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      reff[i] = eff_ratio(ratio_sh[i*CNT_W +: CNT_W]);
      oeff[i] = eff_ofs(ofs_sh[i*CNT_W +: CNT_W], reff[i]);
    end
  end

  // ce/clk_out are registered from the next counter value so they line up with it.
  always_comb begin
    run_nxt  = (state_nxt == RUN);
    do_load  = run_nxt && ((state != RUN) || reload);
    suppress = reload && (state == RUN);
    ce_nxt   = '0;
    clk_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i] = '0;
      if (do_load) begin
        cnt_nxt[i] = oeff[i];
      end else if (run_nxt) begin
        cnt_nxt[i] = (cnt[i] >= reff[i] - CNT_W'(1)) ? '0 : cnt[i] + CNT_W'(1);
      end
      ce_nxt[i]  = run_nxt && !suppress && (cnt_nxt[i] == reff[i] - CNT_W'(1));
      clk_nxt[i] = run_nxt && (cnt_nxt[i] < half_len(reff[i]));
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state        <= RESET_PLL;
      cyc          <= '0;
      sync_p0      <= 1'b0;
      lock_s       <= 1'b0;
      ratio_sh     <= '0;
      ofs_sh       <= '0;
      reload       <= 1'b0;
      relock_count <= '0;
      ce           <= '0;
      clk_out      <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      state   <= state_nxt;
      cyc     <= cyc_nxt;
      sync_p0 <= pll_locked;
      lock_s  <= sync_p0;
      if (cfg_load) begin
        ratio_sh <= div_ratio;
        ofs_sh   <= phase_ofs;
      end
      reload <= cfg_load && (state == RUN) && (state_nxt == RUN);
      if ((state == RUN) && !lock_s) relock_count <= sat_inc8(relock_count);
      ce      <= ce_nxt;
      clk_out <= clk_nxt;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: randomized divider configs checked
// against a phase-arithmetic reference model, plus sequencer timing scenarios.
module tb_clk_div_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int PRC    = 4;
  localparam int LS     = 8;
  localparam int TMO    = 32;
  localparam int SYNC   = 2;
  // cycles from reset release to ready with lock present throughout
  localparam int T_RUN  = ((PRC > SYNC) ? PRC : SYNC) + 1 + LS;

  logic                    refclk;
  logic                    rst;
  logic                    pll_locked;
  logic [NUM_CH*CNT_W-1:0] div_ratio;
  logic [NUM_CH*CNT_W-1:0] phase_ofs;
  logic                    cfg_load;
  logic                    pll_rst;
  logic                    ready;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       clk_out;
  logic [7:0]              relock_count;

  int n_checks = 0;
  int n_errors = 0;
  int cur_r [NUM_CH];
  int cur_o [NUM_CH];
  int new_r [NUM_CH];
  int new_o [NUM_CH];
  int m_reff  [NUM_CH];
  int m_phase [NUM_CH];

  clk_div_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PLL_RST_CYCLES(PRC),
    .LOCK_STABLE(LS), .RELOCK_TIMEOUT(TMO)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .div_ratio(div_ratio), .phase_ofs(phase_ofs), .cfg_load(cfg_load),
    .pll_rst(pll_rst), .ready(ready), .ce(ce), .clk_out(clk_out),
    .relock_count(relock_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int eff_r(input int r);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int eff_o(input int o, input int r);
    return (o < eff_r(r)) ? o : eff_r(r) - 1;
  endfunction

  function automatic logic [NUM_CH*CNT_W-1:0] pack(input int v [NUM_CH]);
    logic [NUM_CH*CNT_W-1:0] b;
    b = '0;
    for (int c = 0; c < NUM_CH; c++) b[c*CNT_W +: CNT_W] = CNT_W'(v[c]);
    return b;
  endfunction

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  task automatic model_start;
    for (int c = 0; c < NUM_CH; c++) begin
      m_reff[c]  = eff_r(cur_r[c]);
      m_phase[c] = eff_o(cur_o[c], cur_r[c]);
    end
  endtask

  // Reset, optionally load cur_r/cur_o during RESET_PLL, wait for ready.
  task automatic bring_up(input string name, input bit load_cfg);
    int t;
    pll_locked = 1'b1;
    rst = 1'b1;
    cfg_load = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    if (load_cfg) begin
      div_ratio = pack(cur_r);
      phase_ofs = pack(cur_o);
      cfg_load  = 1'b1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cur_r[c] = 0;
        cur_o[c] = 0;
      end
    end
    t = 0;
    while (ready !== 1'b1 && t < 60) begin
      tick;
      cfg_load = 1'b0;
      t++;
    end
    n_checks++;
    if (t != T_RUN) begin
      n_errors++;
      $display("FAIL %s startup: ready after %0d cycles, expected %0d", name, t, T_RUN);
    end
    model_start();
  endtask

  // Walk ncyc RUN cycles against the model; optionally issue cfg_load (new_r/new_o) at k == cfg_k.
  task automatic run_window(input string name, input int ncyc, input int cfg_k);
    bit   sup;
    logic exp_ce, exp_clk;
    for (int k = 0; k < ncyc; k++) begin
      sup = 1'b0;
      if (cfg_k >= 0 && k == cfg_k + 2) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_reff[c]  = eff_r(new_r[c]);
          m_phase[c] = eff_o(new_o[c], new_r[c]);
        end
        sup = 1'b1;
      end
      n_checks++;
      if (ready !== 1'b1) begin
        n_errors++;
        $display("FAIL %s ready k=%0d: got %b, expected 1", name, k, ready);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        exp_ce  = (!sup && m_phase[c] == m_reff[c] - 1) ? 1'b1 : 1'b0;
        exp_clk = (m_phase[c] < (m_reff[c] + 1) / 2) ? 1'b1 : 1'b0;
        n_checks++;
        if (ce[c] !== exp_ce) begin
          n_errors++;
          $display("FAIL %s ce[%0d] k=%0d R=%0d: got %b, expected %b", name, c, k, m_reff[c], ce[c], exp_ce);
        end
        n_checks++;
        if (clk_out[c] !== exp_clk) begin
          n_errors++;
          $display("FAIL %s clk_out[%0d] k=%0d R=%0d: got %b, expected %b", name, c, k, m_reff[c], clk_out[c], exp_clk);
        end
      end
      if (k == cfg_k) begin
        div_ratio = pack(new_r);
        phase_ofs = pack(new_o);
        cfg_load  = 1'b1;
      end
      tick;
      cfg_load = 1'b0;
      for (int c = 0; c < NUM_CH; c++) m_phase[c] = (m_phase[c] + 1) % m_reff[c];
    end
    if (cfg_k >= 0) begin
      cur_r = new_r;
      cur_o = new_o;
    end
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if (pll_rst !== 1'b1 || ready !== 1'b0 || ce !== '0 || clk_out !== '0 || relock_count !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_async: pll_rst=%b ready=%b ce=%b clk_out=%b relock=%0d, expected 1 0 000 000 0",
               pll_rst, ready, ce, clk_out, relock_count);
    end
    tick;
    tick;
    n_checks++;
    if (pll_rst !== 1'b1 || ready !== 1'b0 || ce !== '0 || clk_out !== '0 || relock_count !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_held: pll_rst=%b ready=%b ce=%b clk_out=%b relock=%0d, expected 1 0 000 000 0",
               pll_rst, ready, ce, clk_out, relock_count);
    end
  endtask

  task automatic test_startup;
    cur_r = '{4, 5, 1};
    cur_o = '{0, 0, 0};
    pll_locked = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    div_ratio = pack(cur_r);
    phase_ofs = pack(cur_o);
    cfg_load  = 1'b1;
    for (int t = 0; t <= T_RUN; t++) begin
      n_checks++;
      if (pll_rst !== (t < PRC) || ready !== (t >= T_RUN)) begin
        n_errors++;
        $display("FAIL startup t=%0d: pll_rst=%b ready=%b, expected %b %b", t, pll_rst, ready, t < PRC, t >= T_RUN);
      end
      if (t < T_RUN) begin
        n_checks++;
        if (ce !== '0 || clk_out !== '0) begin
          n_errors++;
          $display("FAIL startup_idle t=%0d: ce=%b clk_out=%b, expected 000 000", t, ce, clk_out);
        end
        tick;
        cfg_load = 1'b0;
      end
    end
    model_start();
    run_window("startup_run", 12, -1);
  endtask

  task automatic test_ratios;
    cur_r = '{4, 5, 1};
    cur_o = '{0, 0, 0};
    bring_up("ratios", 1'b1);
    run_window("ratios", 30, -1);
  endtask

  task automatic test_phase;
    int first [NUM_CH];
    int exp_first [NUM_CH];
    cur_r = '{4, 4, 4};
    cur_o = '{0, 1, 7};
    exp_first = '{3, 2, 0};
    bring_up("phase", 1'b1);
    for (int c = 0; c < NUM_CH; c++) first[c] = -1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < NUM_CH; c++)
        if (ce[c] === 1'b1 && first[c] < 0) first[c] = k;
      tick;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++;
      if (first[c] != exp_first[c]) begin
        n_errors++;
        $display("FAIL phase ce[%0d] first pulse: got cycle %0d, expected %0d", c, first[c], exp_first[c]);
      end
    end
  endtask

  task automatic test_reconfig;
    cur_r = '{4, 5, 1};
    cur_o = '{0, 0, 0};
    bring_up("reconfig", 1'b1);
    run_window("reconfig_pre", 5, -1);
    new_r = '{6, 3, 2};
    new_o = '{0, 1, 9};
    run_window("reconfig", 24, 2);
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cur_r[c] = int'($urandom_range(0, 12));
        cur_o[c] = int'($urandom_range(0, 15));
      end
      bring_up("random", 1'b1);
      run_window("random", 30, -1);
      for (int c = 0; c < NUM_CH; c++) begin
        new_r[c] = int'($urandom_range(0, 12));
        new_o[c] = int'($urandom_range(0, 15));
      end
      run_window("random_cfg", 30, int'($urandom_range(0, 20)));
    end
  endtask

  task automatic test_lock_loss;
    int t;
    int exp_cnt;
    cur_r = '{4, 5, 1};
    cur_o = '{0, 0, 0};
    bring_up("lockloss", 1'b1);
    run_window("lockloss_pre", 7, -1);
    pll_locked = 1'b0;
    tick;
    pll_locked = 1'b1;
    tick;
    n_checks++;
    if (ready !== 1'b1) begin
      n_errors++;
      $display("FAIL lockloss_sync_delay: ready=%b, expected 1", ready);
    end
    // cfg_load lands on the same edge as the lock-loss transition
    new_r = '{3, 3, 3};
    new_o = '{2, 0, 1};
    div_ratio = pack(new_r);
    phase_ofs = pack(new_o);
    cfg_load  = 1'b1;
    tick;
    cfg_load = 1'b0;
    t = SYNC + 1;
    n_checks++;
    if (ready !== 1'b0 || pll_rst !== 1'b1 || ce !== '0 || clk_out !== '0 || relock_count !== 8'd1) begin
      n_errors++;
      $display("FAIL lockloss: ready=%b pll_rst=%b ce=%b clk_out=%b relock=%0d, expected 0 1 000 000 1",
               ready, pll_rst, ce, clk_out, relock_count);
    end
    for (int k = 1; k <= PRC; k++) begin
      tick;
      t++;
      n_checks++;
      if (pll_rst !== (k < PRC)) begin
        n_errors++;
        $display("FAIL lockloss_pll_rst k=%0d: got %b, expected %b", k, pll_rst, k < PRC);
      end
    end
    while (ready !== 1'b1 && t < 60) begin
      tick;
      t++;
    end
    n_checks++;
    if (t != SYNC + 1 + PRC + 1 + LS) begin
      n_errors++;
      $display("FAIL lockloss_relock: ready after %0d cycles, expected %0d", t, SYNC + 1 + PRC + 1 + LS);
    end
    cur_r = new_r;
    cur_o = new_o;
    model_start();
    run_window("lockloss_newcfg", 12, -1);

    exp_cnt = 1;
    for (int n = 0; n < 300; n++) begin
      t = 0;
      while (ready !== 1'b1 && t < 40) begin
        tick;
        t++;
      end
      pll_locked = 1'b0;
      tick;
      pll_locked = 1'b1;
      t = 1;
      while (ready !== 1'b0 && t < 10) begin
        tick;
        t++;
      end
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      n_checks++;
      if (ready !== 1'b0 || relock_count !== 8'(exp_cnt)) begin
        n_errors++;
        $display("FAIL relock_count n=%0d: ready=%b count=%0d, expected 0 %0d", n, ready, relock_count, exp_cnt);
      end
    end
    n_checks++;
    if (relock_count !== 8'd255) begin
      n_errors++;
      $display("FAIL relock_saturate: got %0d, expected 255", relock_count);
    end
  endtask

  task automatic test_reset_midrun;
    int t;
    t = 0;
    while (ready !== 1'b1 && t < 40) begin
      tick;
      t++;
    end
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (pll_rst !== 1'b1 || ready !== 1'b0 || ce !== '0 || clk_out !== '0 || relock_count !== 8'd0) begin
      n_errors++;
      $display("FAIL midrun_reset: pll_rst=%b ready=%b ce=%b clk_out=%b relock=%0d, expected 1 0 000 000 0",
               pll_rst, ready, ce, clk_out, relock_count);
    end
    bring_up("midrun_restart", 1'b0);
    run_window("midrun_cleared_cfg", 6, -1);
  endtask

  task automatic test_timeout;
    pll_locked = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 3 * (PRC + TMO); k++) begin
      n_checks++;
      if (pll_rst !== ((k % (PRC + TMO)) < PRC) || ready !== 1'b0 || ce !== '0 || clk_out !== '0) begin
        n_errors++;
        $display("FAIL timeout k=%0d: pll_rst=%b ready=%b ce=%b clk_out=%b, expected pll_rst=%b ready=0",
                 k, pll_rst, ready, ce, clk_out, (k % (PRC + TMO)) < PRC);
      end
      tick;
    end
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    cfg_load   = 1'b0;
    div_ratio  = '0;
    phase_ofs  = '0;
    test_reset();
    test_startup();
    test_ratios();
    test_phase();
    test_reconfig();
    test_random();
    test_lock_loss();
    test_reset_midrun();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
